// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort scheduler and the insertion-sort engine.
package sort_pkg;

  // Default array geometry, shared with the insertionSort engine.
  localparam int NUM_VALS_DEF  = 5;
  localparam int SIZE_DATA_DEF = 8;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    SETUP = 3'd2,
    RUN   = 3'd3,
    RESP  = 3'd4
  } sched_state_t;

  // Larger of two integers; used to size the shared setup/timeout counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Walk the requesters from last+1 (mod NUM_REQ) and take the first one asserted.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_i) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/sort_scheduler.sv
// Shares one insertion-sort engine among NUM_REQ requesters: round-robin grant,
// data hold, setup window before start, timeout watchdog, tagged response.
module sort_scheduler
  import sort_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_VALS  = NUM_VALS_DEF,
  parameter int SIZE_DATA = SIZE_DATA_DEF,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [NUM_REQ-1:0]                     i_req,
  input  logic [NUM_REQ*NUM_VALS*SIZE_DATA-1:0]  i_data,
  output logic [NUM_REQ-1:0]                     o_ack,
  output logic [NUM_REQ-1:0]                     o_done,
  output logic [NUM_VALS*SIZE_DATA-1:0]          o_data,
  output logic                                   o_err,
  output logic                                   o_busy,
  output logic                                   o_eng_start,
  output logic [NUM_VALS*SIZE_DATA-1:0]          o_eng_data,
  input  logic                                   i_eng_done,
  input  logic [NUM_VALS*SIZE_DATA-1:0]          i_eng_data
);

  localparam int DW    = NUM_VALS * SIZE_DATA;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(TIMEOUT, SETUP_CYC) + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);

  sched_state_t        state_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DW-1:0]       hold_q;
  logic [DW-1:0]       res_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                err_q;
  logic                busy_q;
  logic                start_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [DW-1:0]       sel_slice;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (i_req),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Pick the granted requester's slice out of the packed input bus.
  always_comb begin
    sel_slice = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gidx_q == IDX_W'(r)) begin
        sel_slice = i_data[r*DW +: DW];
      end
    end
  end

  // Scheduler FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      hold_q  <= '0;
      res_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gidx_q  <= arb_idx;
            ack_q   <= arb_gnt;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          hold_q  <= sel_slice;
          last_q  <= gidx_q;
          cnt_q   <= '0;
          state_q <= SETUP;
        end
        SETUP: begin
          if (cnt_q >= SETUP_LAST) begin
            cnt_q   <= '0;
            start_q <= 1'b1;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          // A done arriving in the same cycle as the timeout still delivers the result.
          if (i_eng_done) begin
            res_q   <= i_eng_data;
            start_q <= 1'b0;
            done_q  <= NUM_REQ'(1) << gidx_q;
            state_q <= RESP;
          end else if ((TIMEOUT != 0) && (cnt_q == TO_VAL)) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            start_q <= 1'b0;
            done_q  <= NUM_REQ'(1) << gidx_q;
            state_q <= RESP;
          end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          start_q <= 1'b0;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ack       = ack_q;
  assign o_done      = done_q;
  assign o_data      = res_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;
  assign o_eng_start = start_q;
  assign o_eng_data  = hold_q;

endmodule

// File: tb/tb_sort_scheduler.sv
// Bench for sort_scheduler with a behavioural sort engine and a result scoreboard.
module tb_sort_scheduler;

  localparam int NR = 4;
  localparam int DW = 40;
  localparam int TO = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    i_req;
  logic [NR*DW-1:0] i_data;
  logic [NR-1:0]    o_ack;
  logic [NR-1:0]    o_done;
  logic [DW-1:0]    o_data;
  logic             o_err;
  logic             o_busy;
  logic             o_eng_start;
  logic [DW-1:0]    o_eng_data;
  logic             i_eng_done;
  logic [DW-1:0]    i_eng_data;

  sort_scheduler #(
    .NUM_REQ   (NR),
    .NUM_VALS  (5),
    .SIZE_DATA (8),
    .SETUP_CYC (2),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (i_req),
    .i_data      (i_data),
    .o_ack       (o_ack),
    .o_done      (o_done),
    .o_data      (o_data),
    .o_err       (o_err),
    .o_busy      (o_busy),
    .o_eng_start (o_eng_start),
    .o_eng_data  (o_eng_data),
    .i_eng_done  (i_eng_done),
    .i_eng_data  (i_eng_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ascending sort, smallest element in the most significant byte.
  function automatic logic [DW-1:0] sort5(input logic [DW-1:0] v);
    logic [7:0] a[5];
    logic [7:0] t;
    logic [DW-1:0] r;
    for (int i = 0; i < 5; i++) a[i] = v[(4-i)*8 +: 8];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < 5; i++) r[(4-i)*8 +: 8] = a[i];
    return r;
  endfunction

  // Behavioural engine: answers eng_lat cycles after start rises; -1 never answers.
  int   eng_lat = -1;
  logic spur    = 1'b0;
  initial begin
    int   run_cnt;
    logic prev_s;
    run_cnt    = 0;
    prev_s     = 1'b0;
    i_eng_done = 1'b0;
    i_eng_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (o_eng_start) run_cnt = prev_s ? run_cnt + 1 : 0;
      prev_s     = o_eng_start;
      i_eng_done = spur || (o_eng_start && eng_lat >= 0 && run_cnt == eng_lat);
      i_eng_data = spur ? 40'hDEADBEEF5A : sort5(o_eng_data);
    end
  end

  typedef struct {
    logic [NR-1:0] done_vec;
    logic [DW-1:0] data;
    logic          err;
  } sb_t;
  sb_t sb[$];

  int            ack_cnt = 0, done_cnt = 0, start_cnt = 0;
  int            ack_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic [NR-1:0] ack_vec = '0;
  logic          mon_ps  = 1'b0;

  // Output monitor: records events and checks each result against the scoreboard.
  always @(negedge clk) begin
    sb_t e;
    if (o_ack != '0) begin
      ack_cnt++;
      ack_vec = o_ack;
      ack_cyc = cyc;
    end
    if (o_eng_start && !mon_ps) begin
      start_cnt++;
      start_cyc = cyc;
    end
    mon_ps = o_eng_start;
    if (o_done != '0) begin
      done_cnt++;
      done_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(o_done), 64'(0));
      end else begin
        e = sb.pop_front();
        check("done_vec", 64'(o_done), 64'(e.done_vec));
        check("done_data", 64'(o_data), 64'(e.data));
        check("done_err", 64'(o_err), 64'(e.err));
      end
    end else if (o_err) begin
      check("err_without_done", 64'(o_err), 64'(0));
    end
  end

  task automatic wait_ack(input int target, input string nm);
    int k;
    k = 0;
    while (ack_cnt < target && k < 40) begin
      @(posedge clk);
      k++;
    end
    if (ack_cnt < target) check({nm, "_ack_timeout"}, 64'(ack_cnt), 64'(target));
  endtask

  task automatic wait_done(input int target, input string nm);
    int k;
    k = 0;
    while (done_cnt < target && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt < target) check({nm, "_done_timeout"}, 64'(done_cnt), 64'(target));
  endtask

  task automatic push_exp(input int g, input logic [DW-1:0] d, input logic er);
    sb_t e;
    e.done_vec = NR'(1) << g;
    e.data     = d;
    e.err      = er;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ack"},      64'(o_ack),       64'(0));
    check({nm, "_done"},     64'(o_done),      64'(0));
    check({nm, "_err"},      64'(o_err),       64'(0));
    check({nm, "_busy"},     64'(o_busy),      64'(0));
    check({nm, "_start"},    64'(o_eng_start), 64'(0));
    check({nm, "_data"},     64'(o_data),      64'(0));
    check({nm, "_eng_data"}, 64'(o_eng_data),  64'(0));
  endtask

  typedef struct {
    logic [NR-1:0] req;
    int            lat;
    int            gnt;
    logic          err;
    logic [DW-1:0] vals;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int a0, d0, s0, n;
    int order[5];
    logic [DW-1:0] v;

    tbl[0] = '{4'b0001,  3, 0, 1'b0, 40'h0503090107, 40'h0103050709};
    tbl[1] = '{4'b0110,  0, 1, 1'b0, 40'hC80A0A00FF, 40'h000A0AC8FF};
    tbl[2] = '{4'b1001,  5, 3, 1'b0, 40'h0403020100, 40'h0001020304};
    tbl[3] = '{4'b1111,  1, 0, 1'b0, 40'h0909090909, 40'h0909090909};
    tbl[4] = '{4'b1100, TO, 2, 1'b0, 40'h0102030405, 40'h0102030405};
    tbl[5] = '{4'b0100, -1, 2, 1'b1, 40'h1122334455, 40'h0000000000};
    tbl[6] = '{4'b0011,  2, 0, 1'b0, 40'h0701070100, 40'h0001010707};

    rst    = 1'b1;
    i_req  = '0;
    i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table: grant order, latency, collision and timeout.
    for (int t = 0; t < 7; t++) begin
      check("idle_busy", 64'(o_busy), 64'(0));
      for (int r = 0; r < NR; r++) i_data[r*DW +: DW] = {5{8'(8'hE0 + r)}};
      i_data[tbl[t].gnt*DW +: DW] = tbl[t].vals;
      eng_lat = tbl[t].lat;
      push_exp(tbl[t].gnt, tbl[t].exp, tbl[t].err);
      a0 = ack_cnt; d0 = done_cnt; s0 = start_cnt; n = cyc;
      i_req = tbl[t].req;
      wait_ack(a0 + 1, "tbl");
      #1;
      i_req = '0;
      check("tbl_ack_vec", 64'(ack_vec), 64'(NR'(1) << tbl[t].gnt));
      check("tbl_ack_lat", 64'(ack_cyc - n), 64'(1));
      check("tbl_busy", 64'(o_busy), 64'(1));
      wait_done(d0 + 1, "tbl");
      #1;
      check("tbl_start_lat", 64'(start_cyc - n), 64'(4));
      check("tbl_done_lat", 64'(done_cyc - start_cyc),
            64'((tbl[t].lat < 0) ? TO + 1 : tbl[t].lat + 1));
      check("tbl_start_cnt", 64'(start_cnt - s0), 64'(1));
    end

    // Spurious engine done in IDLE and in SETUP.
    a0 = ack_cnt; d0 = done_cnt;
    spur = 1'b1;
    @(posedge clk);
    #1;
    spur = 1'b0;
    @(posedge clk);
    #1;
    check("spur_idle_busy", 64'(o_busy), 64'(0));
    check("spur_idle_ack", 64'(ack_cnt), 64'(a0));
    check("spur_idle_done", 64'(done_cnt), 64'(d0));
    i_data[2*DW +: DW] = 40'h3030101020;
    eng_lat = 2;
    push_exp(2, 40'h1010203030, 1'b0);
    n = cyc;
    i_req = 4'b0100;
    wait_ack(a0 + 1, "spur");
    #1;
    i_req = '0;
    spur  = 1'b1;
    @(posedge clk);
    #1;
    spur = 1'b0;
    check("spur_setup_done", 64'(done_cnt), 64'(d0));
    wait_done(d0 + 1, "spur");
    #1;
    check("spur_start_lat", 64'(start_cyc - n), 64'(4));
    check("spur_done_lat", 64'(done_cyc - start_cyc), 64'(3));

    // Fairness with all requesters asserted, starting from reset.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    for (int r = 0; r < NR; r++)
      i_data[r*DW +: DW] = {8'(9 - r), 8'(r), 8'(3*r + 1), 8'd7, 8'(2*r)};
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      v = i_data[order[k]*DW +: DW];
      push_exp(order[k], sort5(v), 1'b0);
    end
    eng_lat = 1;
    a0 = ack_cnt; d0 = done_cnt;
    @(posedge clk);
    #1;
    i_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a0 + k + 1, "fair");
      #1;
      check("fair_grant", 64'(ack_vec), 64'(NR'(1) << order[k]));
      i_req = (k == 4) ? '0 : (i_req & ~ack_vec);
      @(posedge clk);
      #1;
      if (k < 4) i_req = 4'b1111;
      wait_done(d0 + k + 1, "fair");
      #1;
    end

    // Reset while the engine is running, then a fresh request.
    eng_lat = -1;
    i_data[2*DW +: DW] = 40'h0102030405;
    push_exp(2, 40'h0102030405, 1'b0);
    a0 = ack_cnt; s0 = start_cnt;
    i_req = 4'b0100;
    wait_ack(a0 + 1, "rstrun");
    #1;
    i_req = '0;
    for (int k = 0; k < 20 && start_cnt == s0; k++) @(posedge clk);
    check("rstrun_started", 64'(start_cnt - s0), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    check("rstrun_in_run", 64'(o_eng_start), 64'(1));
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check_reset_outputs("rstrun");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("rstrun_no_done", 64'(done_cnt), 64'(d0));
    i_data[0*DW +: DW] = 40'h0908070605;
    i_data[3*DW +: DW] = 40'hFFFFFFFFFF;
    eng_lat = 0;
    push_exp(0, 40'h0506070809, 1'b0);
    a0 = ack_cnt;
    i_req = 4'b1001;
    wait_ack(a0 + 1, "after_rst");
    #1;
    i_req = '0;
    check("after_rst_grant", 64'(ack_vec), 64'(4'b0001));
    wait_done(d0 + 1, "after_rst");
    #1;
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_scheduler.md
# sort_scheduler

Round-robin scheduler that shares one insertion-sort engine among `NUM_REQ` requesters. It accepts a packed array from the winning requester and holds it in a local register. It then sequences the engine's start/done handshake, including a setup window and a timeout watchdog, and returns the sorted result tagged to the original requester. The block sits between the client ports and a single `insertionSort` instance.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `NUM_VALS`, 5, elements per array (matches engine)
- `SIZE_DATA`, 8, bits per element (matches engine)
- `SETUP_CYC`, 2, cycles `o_eng_data` is stable before `o_eng_start` rises (≥2)
- `TIMEOUT`, 255, max RUN cycles before abort; 0 disables watchdog

Ports (one clock `i_clk`; reset `i_rst` is asynchronous and active-high):
- `i_clk`  in  1  clock
- `i_rst`  in  1  async active-high reset
- `i_req`  in  NUM_REQ  per-requester request level
- `i_data`  in  NUM_REQ*NUM_VALS*SIZE_DATA  requester r array at `[r*NUM_VALS*SIZE_DATA +: NUM_VALS*SIZE_DATA]`
- `o_ack`  out  NUM_REQ  one-hot, 1-cycle pulse: data captured
- `o_done`  out  NUM_REQ  one-hot, 1-cycle pulse: result valid on `o_data`
- `o_data`  out  NUM_VALS*SIZE_DATA  result bus, shared by all requesters
- `o_err`  out  1  1-cycle pulse together with `o_done` on timeout
- `o_busy`  out  1  high in every state except IDLE
- `o_eng_start`  out  1  to engine `i_start`
- `o_eng_data`  out  NUM_VALS*SIZE_DATA  to engine `i_data`
- `i_eng_done`  in  1  engine `o_done`
- `i_eng_data`  in  NUM_VALS*SIZE_DATA  engine `o_data`

## Operation
- FSM states: IDLE, GRANT, SETUP, RUN, RESP.
- IDLE: if any `i_req` is set, pick the winner round-robin. The search starts at `last+1` mod `NUM_REQ`. Register the grant index `g`, then go to GRANT.
- GRANT (1 cycle):
  - `o_ack[g]`=1.
  - Capture `i_data` slice g into the hold register.
  - Set `last<=g`; clear the counter; go to SETUP.
- SETUP: `o_eng_data` = hold register. Count `SETUP_CYC` cycles, then go to RUN.
- RUN:
  - `o_eng_start`=1 for the whole state.
  - On `i_eng_done`: capture `i_eng_data` into the result register, then go to RESP.
  - Otherwise, if `TIMEOUT`≠0 and the counter reaches `TIMEOUT`: zero the result register, set the error flag, then go to RESP.
  - `i_eng_done` and timeout in the same cycle: done wins, no error.
- RESP (1 cycle):
  - `o_done[g]`=1 and `o_data` = result register.
  - `o_err`=1 only if the error flag is set; the flag clears on exit.
  - Return to IDLE.
- `o_data` holds its value until the next RESP.
- Requesters hold `i_req` and their slice stable until `o_ack`, then drop `i_req` the next cycle. A request still high in a later IDLE is treated as a new request.
- `i_eng_done` outside RUN is ignored.
- Counter width is `$clog2(max(TIMEOUT,SETUP_CYC)+1)`. It saturates and never wraps.

## Timing
- All outputs are registered.
- Reset values:
  - `o_ack`, `o_done`, `o_err`, `o_busy`, `o_eng_start` = 0.
  - `o_data`, `o_eng_data`, hold and result registers = 0.
  - state = IDLE; `last` = `NUM_REQ-1`, so requester 0 has first priority after reset.
- Request high in IDLE cycle n: `o_ack` at n+1, first start-high cycle at n+2+`SETUP_CYC`.
- Engine done seen in RUN cycle m: `o_done`/`o_data` at m+1, `o_eng_start` low at m+1, IDLE at m+2.
- The 1-cycle start drop guarantees the engine's wait state samples start low before its next run.
- Reset asserted mid-operation: immediate return to reset values, no `o_done`. The engine shares `i_rst` at system level.
- Back-to-back requesters: minimum cycle per job is engine latency + `SETUP_CYC` + 3.

## Structure
- Package `sort_pkg`: the `sched_state_t` enum; the default `NUM_VALS`/`SIZE_DATA` constants, shared with `insertionSort`.
- One sub-module: `rr_arbiter` (combinational, `NUM_REQ` wide). Inputs are the request vector and `last`; outputs are the one-hot grant and its index.
- The engine is instantiated at the level above, not inside this block.

## Test plan
- Single request: `i_req`=0001, data {5,3,9,1,7}, behavioural engine.
  - `o_ack`=0001 at n+1, start high at n+4.
  - `o_done`=0001 with `o_data`={1,3,5,7,9}, `o_err`=0.
- Fairness: `i_req`=1111 held, re-raised after each ack. Grant order 0,1,2,3,0; no requester granted twice before all others are served.
- Timeout: `TIMEOUT`=10, engine never answers. `o_done` and `o_err` pulse 11 cycles after start rises, `o_data`=0, next request still served.
- Done/timeout collision: `i_eng_done` in the exact cycle the counter hits `TIMEOUT`. `o_err`=0 and the engine result is delivered.
- Reset in RUN: assert `i_rst` 3 cycles after start. All outputs 0 immediately, no `o_done`; a fresh request after release is granted to requester 0.
- Spurious done: `i_eng_done` pulsed while IDLE and while in SETUP. No state change, no output pulse.
